// File: rtl/bscan_dtm_ctrl.sv
// ----------------------------------------------------------------------------
// bscan_dtm_ctrl
//
// Debug-transport controller that sits behind a BSCANE2 USER chain. It owns
// the DR shift register, reports status on Capture-DR and turns each
// Update-DR edge into at most one register read or write toward the debug
// module.
//
// DR layout (LSB is shifted first):
//   sr[1:0]                         op / status
//   sr[DATA_BITS+1:2]               data
//   sr[DR_BITS-1:DATA_BITS+2]       addr
//
// Ports:
//   clock, reset         TCK-derived clock, synchronous active-high reset
//   bscan_sel            USER instruction selected; qualifies all bscan_* inputs
//   bscan_capture        Capture-DR
//   bscan_shift          Shift-DR
//   bscan_update         Update-DR level (acted on at its rising edge)
//   bscan_reset          TAP test-logic-reset (clears chain-side state only)
//   bscan_tdi/bscan_tdo  serial in / out
//   req_*                register-access request (valid/ready handshake)
//   resp_*               single-cycle response from the debug module
//   busy                 a transaction is in flight
// ----------------------------------------------------------------------------
module bscan_dtm_ctrl #(
    parameter int unsigned ADDR_BITS = 7,
    parameter int unsigned DATA_BITS = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 bscan_sel,
    input  logic                 bscan_capture,
    input  logic                 bscan_shift,
    input  logic                 bscan_update,
    input  logic                 bscan_reset,
    input  logic                 bscan_tdi,
    output logic                 bscan_tdo,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic                 req_write,
    output logic [ADDR_BITS-1:0] req_addr,
    output logic [DATA_BITS-1:0] req_wdata,
    input  logic                 resp_valid,
    input  logic [DATA_BITS-1:0] resp_rdata,
    input  logic                 resp_error,
    output logic                 busy
);

    localparam int unsigned DR_BITS = ADDR_BITS + DATA_BITS + 2;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [1:0] ST_OK    = 2'd0;
    localparam logic [1:0] ST_ERR   = 2'd2;
    localparam logic [1:0] ST_BUSY  = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } state_t;

    state_t               r_state;
    logic [DR_BITS-1:0]   r_sr;
    logic                 r_sticky_err;
    logic                 r_sticky_busy;
    logic [ADDR_BITS-1:0] r_last_addr;
    logic [DATA_BITS-1:0] r_last_rdata;
    logic                 r_upd_q;
    logic                 r_req_valid;
    logic                 r_req_write;
    logic [ADDR_BITS-1:0] r_req_addr;
    logic [DATA_BITS-1:0] r_req_wdata;
    logic                 r_busy;

    logic                 w_capture;
    logic                 w_shift;
    logic                 w_upd_lvl;
    logic                 w_upd_rise;
    logic [1:0]           w_op;
    logic [DATA_BITS-1:0] w_sr_data;
    logic [ADDR_BITS-1:0] w_sr_addr;
    logic [1:0]           w_status;
    logic                 w_is_access;

    // Chain qualifiers; capture takes priority over shift.
    assign w_capture  = bscan_sel & bscan_capture;
    assign w_shift    = bscan_sel & bscan_shift & ~bscan_capture;
    assign w_upd_lvl  = bscan_sel & bscan_update;
    assign w_upd_rise = w_upd_lvl & ~r_upd_q;

    // Fields decoded from the pre-edge shift register contents.
    assign w_op        = r_sr[1:0];
    assign w_sr_data   = r_sr[DATA_BITS+1:2];
    assign w_sr_addr   = r_sr[DR_BITS-1:DATA_BITS+2];
    assign w_is_access = (w_op == OP_READ) || (w_op == OP_WRITE);

    // Busy outranks error in the reported status.
    always_comb begin
        w_status = ST_OK;
        if ((r_state != StIdle) || r_sticky_busy) begin
            w_status = ST_BUSY;
        end else if (r_sticky_err) begin
            w_status = ST_ERR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= StIdle;
            r_sr          <= '0;
            r_sticky_err  <= 1'b0;
            r_sticky_busy <= 1'b0;
            r_last_addr   <= '0;
            r_last_rdata  <= '0;
            r_upd_q       <= 1'b0;
            r_req_valid   <= 1'b0;
            r_req_write   <= 1'b0;
            r_req_addr    <= '0;
            r_req_wdata   <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_upd_q <= w_upd_lvl;

            if (bscan_reset) begin
                // Chain-side state only; the bus transaction carries on.
                r_sr          <= '0;
                r_sticky_err  <= 1'b0;
                r_sticky_busy <= 1'b0;
                r_upd_q       <= 1'b0;
            end else begin
                if (w_capture) begin
                    r_sr <= {r_last_addr, r_last_rdata, w_status};
                end else if (w_shift) begin
                    r_sr <= {bscan_tdi, r_sr[DR_BITS-1:1]};
                end

                if (w_upd_rise) begin
                    if (w_op == OP_CLEAR) begin
                        // Clears bookkeeping only; an in-flight access is not aborted.
                        r_sticky_busy <= 1'b0;
                        r_sticky_err  <= 1'b0;
                    end else if (w_is_access) begin
                        if (r_state != StIdle) begin
                            r_sticky_busy <= 1'b1;
                        end else if (!r_sticky_busy && !r_sticky_err) begin
                            r_req_addr  <= w_sr_addr;
                            r_req_wdata <= w_sr_data;
                            r_req_write <= (w_op == OP_WRITE);
                            r_last_addr <= w_sr_addr;
                            r_req_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= StReq;
                        end
                    end
                end
            end

            // Bus side. Placed last so a response error lands even if a
            // clear-sticky update happens in the same cycle.
            case (r_state)
                StReq: begin
                    if (req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= StWait;
                    end
                end
                StWait: begin
                    if (resp_valid) begin
                        if (!r_req_write) begin
                            r_last_rdata <= resp_rdata;
                        end
                        if (resp_error) begin
                            r_sticky_err <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bscan_tdo = r_sr[0];
    assign req_valid = r_req_valid;
    assign req_write = r_req_write;
    assign req_addr  = r_req_addr;
    assign req_wdata = r_req_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_bscan_dtm_ctrl.sv
module tb_bscan_dtm_ctrl;

    logic        clock;
    logic        reset;
    logic        bscan_sel;
    logic        bscan_capture;
    logic        bscan_shift;
    logic        bscan_update;
    logic        bscan_reset;
    logic        bscan_tdi;
    logic        bscan_tdo;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        busy;

    bscan_dtm_ctrl #(
        .ADDR_BITS(7),
        .DATA_BITS(32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bscan_sel    (bscan_sel),
        .bscan_capture(bscan_capture),
        .bscan_shift  (bscan_shift),
        .bscan_update (bscan_update),
        .bscan_reset  (bscan_reset),
        .bscan_tdi    (bscan_tdi),
        .bscan_tdo    (bscan_tdo),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Expected request {write, addr, wdata} and expected/observed DR scans.
    logic [39:0] exp_req_q[$];
    logic [40:0] exp_dr_q[$];
    logic [40:0] got_dr_q[$];
    string       dr_name_q[$];

    // Responder configuration.
    int          ready_delay = 2;
    int          resp_gap    = 0;
    logic [31:0] cfg_rdata   = 32'h0;
    logic        cfg_err     = 1'b0;
    logic        resp_block  = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full capture + 41-bit shift; records the shifted-out DR for the monitor.
    task automatic scan(input string name, input logic [40:0] din, input logic [40:0] exp_out);
        logic [40:0] dout;
        dout = '0;
        bscan_capture = 1'b1;
        tick();
        bscan_capture = 1'b0;
        bscan_shift   = 1'b1;
        for (int i = 0; i < 41; i++) begin
            dout[i]   = bscan_tdo;
            bscan_tdi = din[i];
            tick();
        end
        bscan_shift = 1'b0;
        bscan_tdi   = 1'b0;
        exp_dr_q.push_back(exp_out);
        dr_name_q.push_back(name);
        got_dr_q.push_back(dout);
    endtask

    task automatic pulse_update(input int hold);
        bscan_update = 1'b1;
        repeat (hold) tick();
        bscan_update = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk(name, {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_in_wait(input string name);
        int n = 0;
        while (!(busy && !req_valid) && n < 100) begin
            tick();
            n++;
        end
        chk(name, {63'd0, busy && !req_valid}, 64'd1);
    endtask

    // Debug-module model: accepts after ready_delay cycles, responds resp_gap
    // cycles after the cycle following the handshake.
    initial begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_error = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            if (req_valid && !resp_block) begin
                repeat (ready_delay) begin
                    @(posedge clock);
                    #2;
                end
                req_ready = 1'b1;
                @(posedge clock);
                #2;
                req_ready = 1'b0;
                repeat (resp_gap) begin
                    @(posedge clock);
                    #2;
                end
                resp_valid = 1'b1;
                resp_rdata = cfg_rdata;
                resp_error = cfg_err;
                @(posedge clock);
                #2;
                resp_valid = 1'b0;
                resp_error = 1'b0;
                resp_rdata = 32'h0;
            end
        end
    end

    // Monitor: checks every request handshake and every completed DR scan.
    initial begin
        logic [39:0] er;
        logic [40:0] ed;
        logic [40:0] gd;
        string       nm;
        forever begin
            @(negedge clock);
            if (req_valid && req_ready && !reset) begin
                if (exp_req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got w=%0d a=0x%0h d=0x%0h expected none",
                             req_write, req_addr, req_wdata);
                end else begin
                    er = exp_req_q.pop_front();
                    chk("req_fields", {24'd0, req_write, req_addr, req_wdata}, {24'd0, er});
                end
            end
            while (got_dr_q.size() > 0 && exp_dr_q.size() > 0) begin
                gd = got_dr_q.pop_front();
                ed = exp_dr_q.pop_front();
                nm = dr_name_q.pop_front();
                chk(nm, {23'd0, gd}, {23'd0, ed});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bscan_sel     = 1'b1;
        bscan_capture = 1'b0;
        bscan_shift   = 1'b0;
        bscan_update  = 1'b0;
        bscan_reset   = 1'b0;
        bscan_tdi     = 1'b0;
        repeat (3) tick();
        chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
        chk("rst_req_write", {63'd0, req_write}, 64'd0);
        chk("rst_req_addr",  {57'd0, req_addr}, 64'd0);
        chk("rst_req_wdata", {32'd0, req_wdata}, 64'd0);
        chk("rst_busy",      {63'd0, busy}, 64'd0);
        chk("rst_tdo",       {63'd0, bscan_tdo}, 64'd0);
        reset = 1'b0;
        tick();

        // Write
        scan("wr_scan", {7'h10, 32'hDEADBEEF, 2'd2}, 41'd0);
        exp_req_q.push_back({1'b1, 7'h10, 32'hDEADBEEF});
        pulse_update(1);
        chk("wr_busy", {63'd0, busy}, 64'd1);
        wait_idle("wr_idle");

        // Read
        cfg_rdata = 32'h12345678;
        scan("rd_scan", {7'h11, 32'h0, 2'd1}, {7'h10, 32'h0, 2'd0});
        exp_req_q.push_back({1'b0, 7'h11, 32'h0});
        pulse_update(1);
        wait_idle("rd_idle");
        scan("rd_result", 41'd0, {7'h11, 32'h12345678, 2'd0});

        // Busy: second update while waiting for the response
        resp_gap  = 6;
        cfg_rdata = 32'hA5A5A5A5;
        scan("bz_scan", {7'h22, 32'h0, 2'd1}, {7'h11, 32'h12345678, 2'd0});
        exp_req_q.push_back({1'b0, 7'h22, 32'h0});
        pulse_update(1);
        wait_in_wait("bz_in_wait");
        pulse_update(1);
        wait_idle("bz_idle");
        scan("bz_status", 41'd0, {7'h22, 32'hA5A5A5A5, 2'd3});
        scan("bz_clr_scan", {7'h0, 32'h0, 2'd3}, {7'h22, 32'hA5A5A5A5, 2'd3});
        pulse_update(1);
        scan("bz_cleared", 41'd0, {7'h22, 32'hA5A5A5A5, 2'd0});

        // Error sticky blocks further requests until cleared
        resp_gap  = 0;
        cfg_err   = 1'b1;
        cfg_rdata = 32'h0BADF00D;
        scan("er_scan", {7'h33, 32'h0, 2'd1}, {7'h22, 32'hA5A5A5A5, 2'd0});
        exp_req_q.push_back({1'b0, 7'h33, 32'h0});
        pulse_update(1);
        wait_idle("er_idle");
        cfg_err = 1'b0;
        scan("er_status", {7'h34, 32'h0, 2'd1}, {7'h33, 32'h0BADF00D, 2'd2});
        pulse_update(1);
        tick();
        chk("er_dropped_busy", {63'd0, busy}, 64'd0);
        scan("er_clr_scan", {7'h0, 32'h0, 2'd3}, {7'h33, 32'h0BADF00D, 2'd2});
        pulse_update(1);
        scan("er_cleared", 41'd0, {7'h33, 32'h0BADF00D, 2'd0});

        // Update held for 5 cycles gives one request; write keeps last_rdata
        cfg_rdata = 32'h55AA55AA;
        scan("hold_scan", {7'h44, 32'h01020304, 2'd2}, {7'h33, 32'h0BADF00D, 2'd0});
        exp_req_q.push_back({1'b1, 7'h44, 32'h01020304});
        pulse_update(5);
        wait_idle("hold_idle");
        repeat (5) tick();
        scan("hold_result", 41'd0, {7'h44, 32'h0BADF00D, 2'd0});

        // Update with sel low is ignored
        scan("nosel_scan", {7'h45, 32'h11111111, 2'd2}, {7'h44, 32'h0BADF00D, 2'd0});
        bscan_sel    = 1'b0;
        bscan_update = 1'b1;
        repeat (2) tick();
        bscan_update = 1'b0;
        tick();
        bscan_sel = 1'b1;
        repeat (3) tick();
        chk("nosel_busy", {63'd0, busy}, 64'd0);
        chk("nosel_req_valid", {63'd0, req_valid}, 64'd0);

        // bscan_reset during WAIT clears chain state; transaction completes
        resp_gap  = 6;
        cfg_rdata = 32'hCAFEF00D;
        scan("br_scan", {7'h55, 32'h0, 2'd1}, {7'h44, 32'h0BADF00D, 2'd0});
        exp_req_q.push_back({1'b0, 7'h55, 32'h0});
        pulse_update(1);
        wait_in_wait("br_in_wait");
        pulse_update(1);
        bscan_reset = 1'b1;
        tick();
        bscan_reset = 1'b0;
        chk("br_tdo", {63'd0, bscan_tdo}, 64'd0);
        chk("br_busy", {63'd0, busy}, 64'd1);
        wait_idle("br_idle");
        scan("br_result", 41'd0, {7'h55, 32'hCAFEF00D, 2'd0});

        // reset during REQ aborts the request
        resp_gap   = 0;
        resp_block = 1'b1;
        scan("rr_scan", {7'h66, 32'h0, 2'd1}, {7'h55, 32'hCAFEF00D, 2'd0});
        pulse_update(1);
        chk("rr_req_valid", {63'd0, req_valid}, 64'd1);
        reset = 1'b1;
        tick();
        chk("rr_abort_valid", {63'd0, req_valid}, 64'd0);
        chk("rr_abort_busy", {63'd0, busy}, 64'd0);
        reset      = 1'b0;
        resp_block = 1'b0;
        tick();
        scan("rr_result", 41'd0, 41'd0);

        repeat (3) tick();
        chk("req_queue_empty", exp_req_q.size(), 64'd0);
        chk("dr_queue_empty", exp_dr_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bscan_dtm_ctrl.md
Name: bscan_dtm_ctrl

Overview:
- Debug-transport controller behind the BSCANE2 USER chain. It sequences capture, shift and update of a 41-bit user data register (DR) and turns each completed update into one read or write on a register-access request/response interface toward the debug module.
- It reports transaction status back through the next DR capture and owns the busy and error bookkeeping for the chain.

Parameters:
ADDR_BITS, 7, register address width
DATA_BITS, 32, register data width
(derived, not overridable) DR_BITS = ADDR_BITS+DATA_BITS+2 = 41

Ports:
clock  input  1  TCK-derived clock; all logic on rising edge
reset  input  1  synchronous, active-high; full reset
bscan_sel  input  1  USER instruction selected
bscan_capture  input  1  Capture-DR
bscan_shift  input  1  Shift-DR
bscan_update  input  1  Update-DR level
bscan_reset  input  1  TAP test-logic-reset, synchronous
bscan_tdi  input  1  serial in
bscan_tdo  output  1  serial out
req_valid  output  1  request valid
req_ready  input  1  request accepted
req_write  output  1  1=write, 0=read
req_addr  output  ADDR_BITS  request address
req_wdata  output  DATA_BITS  write data
resp_valid  input  1  response valid, single-cycle
resp_rdata  input  DATA_BITS  read data
resp_error  input  1  response error
busy  output  1  transaction in flight

Behaviour:
- DR layout, LSB shifted first: sr[1:0]=op, sr[33:2]=data, sr[40:34]=addr.
- Shift-in op codes: 0 nop, 1 read, 2 write, 3 clear-sticky.
- Capture op field is status: 0 ok, 2 error, 3 busy. Busy wins over error.
- Reset: sr=0, state IDLE, sticky_err=0, sticky_busy=0, last_addr=0, last_rdata=0. Outputs req_valid=0, req_write=0, req_addr=0, req_wdata=0, busy=0, bscan_tdo=0.
- Inputs are ignored unless bscan_sel=1.
- Capture (sel&capture): sr <= {last_addr, last_rdata, status}.
  - status=3 if (state!=IDLE or sticky_busy); else 2 if sticky_err; else 0.
- Shift (sel&shift&!capture): sr <= {tdi, sr[40:1]}. Capture has priority over shift.
- bscan_tdo = sr[0], combinational. It is not gated by sel.
- Update: acts on the rising edge of (sel&update), one action per edge. Update never modifies sr.
  - state!=IDLE: set sticky_busy; request dropped.
  - IDLE, op=1 or op=2, sticky_busy=0 and sticky_err=0: latch req_addr=sr[40:34], req_wdata=sr[33:2], req_write=(op==2); last_addr<=sr[40:34]; next state REQ.
  - IDLE, op=1/2, any sticky set: request dropped (no bus activity).
  - op=3: clear sticky_busy and sticky_err. This holds in any state; it does not abort an in-flight transaction.
  - op=0: no action.
- FSM:
  - IDLE: req_valid=0.
  - REQ: req_valid=1; req_write/req_addr/req_wdata held stable. req_ready=1 -> WAIT next cycle.
  - WAIT: req_valid=0. resp_valid=1 -> on reads last_rdata<=resp_rdata (writes leave it unchanged); sticky_err |= resp_error; next state IDLE.
  - resp_valid outside WAIT is ignored. The earliest accepted response is the cycle after the req handshake.
- busy = (state!=IDLE), registered from state.
- bscan_reset (synchronous): clears sr, sticky_err, sticky_busy and the update edge detector. FSM, last_addr and last_rdata are untouched, so an in-flight transaction completes normally.
- reset overrides bscan_reset and aborts any transaction: req_valid=0 the next cycle.
- Capture, shift and update edge in the same cycle: the sr update (capture or shift) and the update action both occur. The update decodes the pre-edge sr value.

Test Plan:
- Write: shift addr=0x10, data=0xDEADBEEF, op=2, pulse update; req_ready=1 after 2 cycles -> exactly one req_valid handshake with req_write=1, req_addr=0x10, req_wdata=0xDEADBEEF; busy 1 until resp_valid.
- Read: shift addr=0x11, op=1, update; respond resp_rdata=0x12345678 one cycle after accept; capture -> shifted-out DR = {0x11, 0x12345678, 0} (41 bits).
- Busy: a second update while in WAIT -> no second request; capture returns status 3 even after the response. Shift op=3 and update -> next capture status 0.
- Error: resp_error=1 on a read -> capture status 2. A following read update issues no request until op=3 is shifted and updated.
- Update held high for 5 cycles -> one request only. Update with sel=0 -> no request.
- bscan_reset during WAIT -> sr and sticky flags cleared, busy stays 1, response still accepted. reset during REQ -> req_valid=0 and busy=0 the next cycle.
